// File: rtl/arvi_bus_pkg.sv
// Shared types and constants for the ARVI bus arbiter and related interconnect blocks.
package arvi_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int          BYTE_EN_W        = 4;
  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: grants the first requester at or after ptr,
// scanning upward with wrap. Reusable by other interconnect blocks.
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (int'(ptr) + i) % N;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus slave port between N_MASTERS masters.
// Optional watchdog (adds o_timeout) enabled by defining ARVI_BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_MASTERS-1:0]           i_m_bus_en,
  input  logic [N_MASTERS-1:0]           i_m_wr_en,
  input  logic [N_MASTERS*XLEN-1:0]      i_m_addr,
  input  logic [N_MASTERS*XLEN-1:0]      i_m_wr_data,
  input  logic [N_MASTERS*BYTE_EN_W-1:0] i_m_byte_en,
  output logic [N_MASTERS-1:0]           o_m_ack,
  output logic [XLEN-1:0]                o_m_rd_data,
  output logic [N_MASTERS-1:0]           o_grant,
  output logic                           o_s_bus_en,
  output logic                           o_s_wr_en,
  output logic [XLEN-1:0]                o_s_addr,
  output logic [XLEN-1:0]                o_s_wr_data,
  output logic [BYTE_EN_W-1:0]           o_s_byte_en,
  input  logic                           i_s_ack,
  input  logic [XLEN-1:0]                i_s_rd_data
`ifdef ARVI_BUS_ARB_TIMEOUT_EN
  ,
  output logic                           o_timeout
`endif
);

  localparam int PW = $clog2(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("bus_arbiter: parameter out of range");
  end

  arb_state_t           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q;
  logic [PW-1:0]        grant_idx_q;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

  logic [N_MASTERS-1:0] pick_gnt;
  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;
  logic                 sel_wr_en;
  logic [XLEN-1:0]      sel_addr, sel_wr_data;
  logic [BYTE_EN_W-1:0] sel_byte_en;

  logic load, txn_done, ack_fire;

  rr_picker #(.N(N_MASTERS)) u_picker (
    .req   (i_m_bus_en),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // One-hot mux of the winning master's request fields.
  always_comb begin
    pick_idx    = '0;
    sel_wr_en   = 1'b0;
    sel_addr    = '0;
    sel_wr_data = '0;
    sel_byte_en = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (pick_gnt[k]) begin
        pick_idx    = PW'(k);
        sel_wr_en   = i_m_wr_en[k];
        sel_addr    = i_m_addr[k*XLEN +: XLEN];
        sel_wr_data = i_m_wr_data[k*XLEN +: XLEN];
        sel_byte_en = i_m_byte_en[k*BYTE_EN_W +: BYTE_EN_W];
      end
    end
  end

`ifdef ARVI_BUS_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q;
  logic        timeout_hit;

  // Fires on the TIMEOUT_CYCLES-th BUSY cycle; a real ack in that cycle wins.
  assign timeout_hit = (state_q == BUSY) && !i_s_ack && (to_cnt_q == TO_LAST);
  assign o_timeout   = timeout_hit;
  assign ack_fire    = i_s_ack | timeout_hit;
  assign o_m_rd_data = timeout_hit ? XLEN'(ARB_TIMEOUT_DATA) : i_s_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_rst || load) begin
      to_cnt_q <= '0;
    end else if (state_q == BUSY) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end
`else
  assign ack_fire    = i_s_ack;
  assign o_m_rd_data = i_s_rd_data;
`endif

  assign txn_done = (state_q == BUSY) && ack_fire;
  assign o_m_ack  = grant_q & {N_MASTERS{txn_done}};
  assign o_grant  = grant_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          load    = 1'b1;
        end
      end
      BUSY: begin
        if (ack_fire) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_idx_q == PW'(N_MASTERS - 1)) ? '0 : grant_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (i_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      o_s_bus_en  <= 1'b0;
      o_s_wr_en   <= 1'b0;
      o_s_addr    <= '0;
      o_s_wr_data <= '0;
      o_s_byte_en <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        grant_q     <= pick_gnt;
        grant_idx_q <= pick_idx;
        o_s_bus_en  <= 1'b1;
        o_s_wr_en   <= sel_wr_en;
        o_s_addr    <= sel_addr;
        o_s_wr_data <= sel_wr_data;
        o_s_byte_en <= sel_byte_en;
      end else if (txn_done) begin
        grant_q     <= '0;
        o_s_bus_en  <= 1'b0;
        o_s_wr_en   <= 1'b0;
        o_s_addr    <= '0;
        o_s_wr_data <= '0;
        o_s_byte_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (N_MASTERS=2, XLEN=32).
// The watchdog scenario is included when ARVI_BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_m_bus_en, i_m_wr_en;
  logic [63:0] i_m_addr, i_m_wr_data;
  logic [7:0]  i_m_byte_en;
  logic [1:0]  o_m_ack, o_grant;
  logic [31:0] o_m_rd_data;
  logic        o_s_bus_en, o_s_wr_en;
  logic [31:0] o_s_addr, o_s_wr_data;
  logic [3:0]  o_s_byte_en;
  logic        i_s_ack;
  logic [31:0] i_s_rd_data;
`ifdef ARVI_BUS_ARB_TIMEOUT_EN
  logic        o_timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] RR_EXP [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  always #5 i_clk = ~i_clk;

  bus_arbiter #(.N_MASTERS(2), .XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_m_bus_en  (i_m_bus_en),
    .i_m_wr_en   (i_m_wr_en),
    .i_m_addr    (i_m_addr),
    .i_m_wr_data (i_m_wr_data),
    .i_m_byte_en (i_m_byte_en),
    .o_m_ack     (o_m_ack),
    .o_m_rd_data (o_m_rd_data),
    .o_grant     (o_grant),
    .o_s_bus_en  (o_s_bus_en),
    .o_s_wr_en   (o_s_wr_en),
    .o_s_addr    (o_s_addr),
    .o_s_wr_data (o_s_wr_data),
    .o_s_byte_en (o_s_byte_en),
    .i_s_ack     (i_s_ack),
    .i_s_rd_data (i_s_rd_data)
`ifdef ARVI_BUS_ARB_TIMEOUT_EN
    ,
    .o_timeout   (o_timeout)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst       = 1'b1;
    i_m_bus_en  = '0;
    i_m_wr_en   = '0;
    i_m_addr    = '0;
    i_m_wr_data = '0;
    i_m_byte_en = '0;
    i_s_ack     = 1'b0;
    i_s_rd_data = '0;
    tick();
    tick();
    check("rst_s_bus_en", 64'(o_s_bus_en), 64'd0);
    check("rst_grant",    64'(o_grant),    64'd0);
    check("rst_m_ack",    64'(o_m_ack),    64'd0);
    check("rst_s_addr",   64'(o_s_addr),   64'd0);
    i_rst = 1'b0;

    // Master 0 alone: read at 0x100, slave acks 3 cycles after o_s_bus_en.
    i_m_bus_en        = 2'b01;
    i_m_addr[31:0]    = 32'h0000_0100;
    i_m_byte_en[3:0]  = 4'hF;
    tick();
    check("t1_s_bus_en",  64'(o_s_bus_en),  64'd1);
    check("t1_s_addr",    64'(o_s_addr),    64'h100);
    check("t1_s_wr_en",   64'(o_s_wr_en),   64'd0);
    check("t1_s_byte_en", 64'(o_s_byte_en), 64'hF);
    check("t1_grant",     64'(o_grant),     64'd1);
    tick();
    check("t1_no_ack_1", 64'(o_m_ack), 64'd0);
    tick();
    check("t1_no_ack_2", 64'(o_m_ack), 64'd0);
    tick();
    i_s_ack     = 1'b1;
    i_s_rd_data = 32'h1234_5678;
    #1;
    check("t1_ack",     64'(o_m_ack),     64'd1);
    check("t1_rd_data", 64'(o_m_rd_data), 64'h1234_5678);
    tick();
    i_s_ack    = 1'b0;
    i_m_bus_en = 2'b00;
    #1;
    check("t1_ack_once",   64'(o_m_ack),    64'd0);
    check("t1_idle_bus",   64'(o_s_bus_en), 64'd0);
    check("t1_idle_grant", 64'(o_grant),    64'd0);
    check("t1_idle_addr",  64'(o_s_addr),   64'd0);

    // Both masters request together straight out of reset.
    i_rst = 1'b1;
    tick();
    i_rst            = 1'b0;
    i_m_bus_en       = 2'b11;
    i_m_addr[63:32]  = 32'h0000_0200;
    tick();
    check("t2_grant_a", 64'(o_grant),  64'd1);
    check("t2_addr_a",  64'(o_s_addr), 64'h100);
    i_s_ack = 1'b1;
    #1;
    check("t2_ack_a", 64'(o_m_ack), 64'd1);
    tick();
    i_s_ack    = 1'b0;
    i_m_bus_en = 2'b10;
    #1;
    check("t2_grant_gap", 64'(o_grant), 64'd0);
    tick();
    check("t2_grant_b", 64'(o_grant),  64'd2);
    check("t2_addr_b",  64'(o_s_addr), 64'h200);
    i_s_ack = 1'b1;
    #1;
    check("t2_ack_b", 64'(o_m_ack), 64'd2);
    tick();
    i_s_ack    = 1'b0;
    i_m_bus_en = 2'b00;

    // Continuous requests from both masters: grants alternate.
    i_m_bus_en = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t3_grant_%0d", i), 64'(o_grant), 64'(RR_EXP[i]));
      i_s_ack = 1'b1;
      #1;
      check($sformatf("t3_ack_%0d", i), 64'(o_m_ack), 64'(RR_EXP[i]));
      tick();
      i_s_ack = 1'b0;
      #1;
      check($sformatf("t3_gap_%0d", i), 64'(o_grant), 64'd0);
    end
    i_m_bus_en = 2'b00;

    // Master 1 write; its inputs change (and bus_en drops) while BUSY.
    i_m_bus_en          = 2'b10;
    i_m_wr_en           = 2'b10;
    i_m_addr[63:32]     = 32'h4000_0040;
    i_m_wr_data[63:32]  = 32'hCAFE_0001;
    i_m_byte_en[7:4]    = 4'b0011;
    tick();
    check("t4_grant",   64'(o_grant),     64'd2);
    check("t4_wr_en",   64'(o_s_wr_en),   64'd1);
    check("t4_addr",    64'(o_s_addr),    64'h4000_0040);
    check("t4_wr_data", 64'(o_s_wr_data), 64'hCAFE_0001);
    check("t4_byte_en", 64'(o_s_byte_en), 64'h3);
    i_m_bus_en          = 2'b00;
    i_m_wr_en           = 2'b00;
    i_m_addr[63:32]     = 32'hFFFF_FFF0;
    i_m_wr_data[63:32]  = 32'h0000_0000;
    i_m_byte_en[7:4]    = 4'hF;
    tick();
    tick();
    check("t4_hold_bus",     64'(o_s_bus_en),  64'd1);
    check("t4_hold_wr_en",   64'(o_s_wr_en),   64'd1);
    check("t4_hold_addr",    64'(o_s_addr),    64'h4000_0040);
    check("t4_hold_wr_data", 64'(o_s_wr_data), 64'hCAFE_0001);
    check("t4_hold_byte_en", 64'(o_s_byte_en), 64'h3);
    check("t4_hold_grant",   64'(o_grant),     64'd2);
    i_s_ack     = 1'b1;
    i_s_rd_data = 32'hA5A5_0000;
    #1;
    check("t4_ack", 64'(o_m_ack), 64'd2);
    tick();
    i_s_ack = 1'b0;
    #1;
    check("t4_done_bus", 64'(o_s_bus_en), 64'd0);

    // Stray ack while IDLE is ignored.
    i_s_ack = 1'b1;
    #1;
    check("t4_stray_ack", 64'(o_m_ack), 64'd0);
    tick();
    i_s_ack = 1'b0;
    #1;
    check("t4_stray_idle", 64'(o_s_bus_en), 64'd0);

    // Reset while BUSY; the late ack must not reach any master.
    i_m_bus_en = 2'b01;
    tick();
    check("t5_busy", 64'(o_s_bus_en), 64'd1);
    i_rst = 1'b1;
    tick();
    i_rst      = 1'b0;
    i_m_bus_en = 2'b00;
    i_s_ack    = 1'b1;
    #1;
    check("t5_ack",    64'(o_m_ack),    64'd0);
    check("t5_bus_en", 64'(o_s_bus_en), 64'd0);
    check("t5_grant",  64'(o_grant),    64'd0);
    check("t5_addr",   64'(o_s_addr),   64'd0);
    check("t5_wr_en",  64'(o_s_wr_en),  64'd0);
    tick();
    i_s_ack = 1'b0;
    #1;
    check("t5_idle_bus", 64'(o_s_bus_en), 64'd0);
    check("t5_idle_ack", 64'(o_m_ack),    64'd0);

`ifdef ARVI_BUS_ARB_TIMEOUT_EN
    // Slave never acks: watchdog fires on BUSY cycle 8 and the other master goes next.
    i_rst = 1'b1;
    tick();
    i_rst      = 1'b0;
    i_m_bus_en = 2'b11;
    tick();
    check("to_grant", 64'(o_grant), 64'd1);
    repeat (6) tick();
    check("to_early", 64'(o_timeout), 64'd0);
    tick();
    check("to_pulse",   64'(o_timeout),   64'd1);
    check("to_ack",     64'(o_m_ack),     64'd1);
    check("to_rd_data", 64'(o_m_rd_data), 64'hDEAD_BEEF);
    tick();
    i_m_bus_en = 2'b10;
    #1;
    check("to_gap_grant", 64'(o_grant),   64'd0);
    check("to_gap_pulse", 64'(o_timeout), 64'd0);
    tick();
    check("to_next_grant", 64'(o_grant), 64'd2);
    i_m_bus_en = 2'b00;
    i_s_ack    = 1'b1;
    tick();
    i_s_ack = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
